// File: rtl/visible_pkg.sv
// Shared types for the visible window array: coordinates, window positions, window indices.
// Window extents are formed one bit wider than a coordinate so far-right windows cannot wrap.
package visible_pkg;

    localparam int unsigned CW = 11;

    typedef logic [CW-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } win_pos_t;

    typedef logic [2:0] win_idx_t;

    // Far edge of a window, carried at CW+1 bits so a window near 2047 never wraps to 0.
    function automatic logic [CW:0] win_end(input coord_t origin, input int unsigned extent);
        return {1'b0, origin} + (CW + 1)'(extent);
    endfunction

endpackage

// File: rtl/visible_window_cmp.sv
// Combinational hit test of one window against the current raster position.
// Produces the hit flag and the window-relative coordinate (valid only when hit is set).
module visible_window_cmp
    import visible_pkg::*;
#(
    parameter int unsigned WIDTH  = 480,
    parameter int unsigned HEIGHT = 360
) (
    input  logic [CW-1:0] i_hc,
    input  logic [CW-1:0] i_vc,
    input  win_pos_t      i_pos,
    output logic          o_hit,
    output logic [CW-1:0] o_local_x,
    output logic [CW-1:0] o_local_y
);

    logic [CW:0] w_x_end;
    logic [CW:0] w_y_end;
    logic        w_in_x;
    logic        w_in_y;

    assign w_x_end = win_end(i_pos.x, WIDTH);
    assign w_y_end = win_end(i_pos.y, HEIGHT);

    // Origin pixel itself is outside; the window covers origin+1 .. origin+extent.
    assign w_in_x = (i_hc > i_pos.x) && ({1'b0, i_hc} <= w_x_end);
    assign w_in_y = (i_vc > i_pos.y) && ({1'b0, i_vc} <= w_y_end);

    assign o_hit     = w_in_x && w_in_y;
    assign o_local_x = i_hc - i_pos.x;
    assign o_local_y = i_vc - i_pos.y;

endmodule

// File: rtl/visible_window_array.sv
// Array of N_WIN movable windows with registered hit flags and lowest-index priority select.
// Position updates are staged in a single pending slot and applied only at frame start.
module visible_window_array
    import visible_pkg::*;
#(
    parameter int unsigned N_WIN  = 4,
    parameter int unsigned WIDTH  = 480,
    parameter int unsigned HEIGHT = 360
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    hc,
    input  logic [CW-1:0]    vc,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_idx,
    input  logic [CW-1:0]    wr_x,
    input  logic [CW-1:0]    wr_y,
    output logic [N_WIN-1:0] visible,
    output logic             hit_any,
    output logic [2:0]       hit_idx,
    output logic [CW-1:0]    local_x,
    output logic [CW-1:0]    local_y
);

    win_pos_t      r_pos [N_WIN];
    logic          r_pend_full;
    win_idx_t      r_pend_idx;
    win_pos_t      r_pend_pos;

    logic [N_WIN-1:0] r_visible;
    logic             r_hit_any;
    win_idx_t         r_hit_idx;
    coord_t           r_local_x;
    coord_t           r_local_y;

    logic [N_WIN-1:0] w_hit;
    coord_t           w_local_x [N_WIN];
    coord_t           w_local_y [N_WIN];
    logic             w_frame_start;
    logic             w_accept;
    logic             w_apply;
    logic             w_sel_any;
    win_idx_t         w_sel_idx;
    coord_t           w_sel_x;
    coord_t           w_sel_y;

    assign w_frame_start = (hc == '0) && (vc == '0);
    assign w_accept      = wr_valid && !r_pend_full;
    assign w_apply       = w_frame_start && r_pend_full;
    assign wr_ready      = !r_pend_full;

    for (genvar g = 0; g < N_WIN; g++) begin : g_win
        visible_window_cmp #(
            .WIDTH  (WIDTH),
            .HEIGHT (HEIGHT)
        ) u_cmp (
            .i_hc      (hc),
            .i_vc      (vc),
            .i_pos     (r_pos[g]),
            .o_hit     (w_hit[g]),
            .o_local_x (w_local_x[g]),
            .o_local_y (w_local_y[g])
        );
    end

    // Pending slot: an accept can only happen while empty, so it never collides with an apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_pend_idx  <= '0;
            r_pend_pos  <= '0;
        end else if (w_accept) begin
            r_pend_full  <= 1'b1;
            r_pend_idx   <= wr_idx;
            r_pend_pos.x <= wr_x;
            r_pend_pos.y <= wr_y;
        end else if (w_apply) begin
            r_pend_full <= 1'b0;
        end
    end

    // Out-of-range indices match no window and are simply dropped when applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_WIN; i++) begin
                r_pos[i] <= '0;
            end
        end else if (w_apply) begin
            for (int i = 0; i < N_WIN; i++) begin
                if (r_pend_idx == win_idx_t'(i)) begin
                    r_pos[i] <= r_pend_pos;
                end
            end
        end
    end

    // Scan from the top down so the lowest-index hit is the one left standing.
    always_comb begin
        w_sel_any = 1'b0;
        w_sel_idx = '0;
        w_sel_x   = '0;
        w_sel_y   = '0;
        for (int i = int'(N_WIN) - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel_any = 1'b1;
                w_sel_idx = win_idx_t'(i);
                w_sel_x   = w_local_x[i];
                w_sel_y   = w_local_y[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_visible <= '0;
            r_hit_any <= 1'b0;
            r_hit_idx <= '0;
            r_local_x <= '0;
            r_local_y <= '0;
        end else begin
            r_visible <= w_hit;
            r_hit_any <= w_sel_any;
            r_hit_idx <= w_sel_idx;
            r_local_x <= w_sel_x;
            r_local_y <= w_sel_y;
        end
    end

    assign visible = r_visible;
    assign hit_any = r_hit_any;
    assign hit_idx = r_hit_idx;
    assign local_x = r_local_x;
    assign local_y = r_local_y;

endmodule

// File: doc/visible_window_array.md
VISIBLE_WINDOW_ARRAY -- requirements
Module: visible_window_array

Interface
REQ-001 Parameter N_WIN, default 4: number of independent windows; SHALL be 1..8.
REQ-002 Parameter WIDTH, default 480: window width in pixels, common to all windows.
REQ-003 Parameter HEIGHT, default 360: window height in lines, common to all windows.
REQ-004 clk  in  1: single clock for all logic.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 hc  in  11: horizontal pixel counter.
REQ-007 vc  in  11: vertical line counter.
REQ-008 wr_valid  in  1: a position update is offered.
REQ-009 wr_ready  out  1: an update can be accepted.
REQ-010 wr_idx  in  3: target window index.
REQ-011 wr_x, wr_y  in  11 each: new X_POS and Y_POS for the target window.
REQ-012 visible  out  N_WIN: per-window hit bits, registered.
REQ-013 hit_any  out  1: OR of visible, registered.
REQ-014 hit_idx  out  3: lowest-index hit window; 0 when hit_any=0.
REQ-015 local_x, local_y  out  11 each: window-relative coordinate of hit_idx; 0 when hit_any=0.

Function
REQ-016 Window i hit test: (hc > X_i) and (hc <= X_i+WIDTH) and (vc > Y_i) and (vc <= Y_i+HEIGHT).
REQ-017 Sums SHALL be formed at 12 bits, so a window past 2047 never wraps to a low coordinate.
REQ-018 Local coordinates SHALL be hc-X_i and vc-Y_i, range 1..WIDTH and 1..HEIGHT.
REQ-019 All outputs SHALL be registered with exactly 1 cycle latency from hc/vc.
REQ-020 Priority: when windows overlap, the lowest index wins hit_idx, local_x and local_y; visible still shows all hits.
REQ-021 Handshake: an update transfers on a cycle where wr_valid=1 and wr_ready=1; wr_ready=1 exactly when the pending slot is empty.
REQ-022 An accepted update SHALL be stored in a single pending slot (idx, x, y); the slot is full from the next cycle.
REQ-023 Frame start SHALL be the cycle with hc==0 and vc==0.
REQ-024 At frame start, a full pending slot SHALL be copied into the active X/Y of window idx, and the slot SHALL empty.
REQ-025 The new position SHALL take effect for hit tests from the cycle after frame start.
REQ-026 Acceptance and frame start in the same cycle: the update goes to the slot and is applied at the next frame start, not the current one.
REQ-027 wr_idx >= N_WIN SHALL be accepted and discarded at frame start, with no change to any window.
REQ-028 Active positions SHALL never change mid-frame.

Reset
REQ-029 Reset SHALL clear all active X_i/Y_i to 0 and empty the pending slot.
REQ-030 During reset, wr_ready=1 and visible, hit_any, hit_idx, local_x, local_y SHALL all be 0.
REQ-031 Reset during a pending update SHALL discard the update.

Structure
REQ-032 Package visible_pkg SHALL hold: CW=11; typedef coord_t (logic [CW-1:0]); struct win_pos_t {x, y}; typedef win_idx_t (logic [2:0]).
REQ-033 Sub-module visible_window_cmp SHALL implement one combinational window test (REQ-016..018) and be instantiated N_WIN times.
REQ-034 Priority selection and output registers SHALL live in visible_window_array.

Verification
REQ-035 Reset, window 0 at (0,0); hc=1, vc=1 -> next cycle visible[0]=1, local=(1,1). hc=481 -> visible[0]=0. hc=0 -> visible[0]=0.
REQ-036 Write win1=(100,50) mid-frame -> wr_ready=0 until frame start; no change before; hc=101, vc=51 after frame start -> hit_idx=1, local=(1,1).
REQ-037 Write win2=(1900,0) with WIDTH=480; hc=2047 -> hit with local_x=147. hc=10 -> no hit.
REQ-038 Overlapping win0=(0,0) and win1=(10,10); hc=20, vc=20 -> visible=4'b0011, hit_idx=0, local=(20,20).
REQ-039 wr_valid coincides with hc=0, vc=0 -> applied at the following frame start. wr_idx=5 with N_WIN=4 -> no window changes, wr_ready returns to 1.
REQ-040 Assert rst with the slot full -> wr_ready=1 immediately and all outputs=0; after release, positions are (0,0) and the update is lost.
